ren_conv_sched: RTL and testbench
=================================

REN_CONV_SCHED -- requirements
Module: ren_conv_sched

Interface
REQ-001 The block SHALL have these parameters:
- NO_OF_INSTS, 4: number of convolver instances.
- JOB_DEPTH, 8: job FIFO entries (power of 2).
- POLL_GAP, 4: idle cycles between status polls.
- ACK_TMO, 16: Wishbone ack timeout in cycles.
REQ-002 The block SHALL have these ports:
- wb_clk_i  in  1  the only clock.
- wb_rst_i  in  1  reset, synchronous, active-low.
- job_valid_i  in  1  job offered.
- job_ready_o  out  1  FIFO not full.
- job_cfg_i  in  32  control word for the instance.
- wbm_cyc_o  out  1  Wishbone master cycle.
- wbm_stb_o  out  1  Wishbone master strobe.
- wbm_we_o  out  1  Wishbone master write enable.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  Wishbone master address.
- wbm_dat_o  out  32  Wishbone master write data.
- wbm_dat_i  in  32  Wishbone master read data.
- wbm_ack_i  in  1  slave ack.
- busy_o  out  NO_OF_INSTS  per-instance busy flags.
- done_cnt_o  out  16  completed jobs.
- err_o  out  1  sticky ack timeout flag.
REQ-003 Instance i SHALL sit at base {8'h30+i, 24'h0}. CTRL is at offset 0x00 (write). STATUS is at offset 0x04 (read, bit0 = done).

Function
REQ-004 A job SHALL be pushed into the FIFO on an edge with job_valid_i && job_ready_o. job_ready_o SHALL be low when the FIFO is full.
REQ-005 The FSM SHALL have four states: IDLE, WR, RD, GAP. Only one Wishbone transaction SHALL be outstanding at a time.
REQ-006 In IDLE, dispatch has priority. If the FIFO is non-empty and any busy_o bit is 0, go to WR. Target the first free instance at or after rr_ptr, wrapping round.
REQ-007 Otherwise in IDLE, if busy_o != 0 and the poll timer = 0, go to RD. Target the next busy instance after poll_ptr, wrapping round.
REQ-008 In WR:
- wbm_cyc_o = wbm_stb_o = wbm_we_o = 1.
- wbm_sel_o = 4'hF.
- wbm_adr_o = CTRL address.
- wbm_dat_o = FIFO head with bit0 forced to 1 (start).
REQ-009 On ack in WR:
- pop the FIFO;
- set the target's busy bit;
- set rr_ptr = target+1 (mod NO_OF_INSTS);
- go to IDLE.
REQ-010 In RD: wbm_cyc_o = wbm_stb_o = 1, wbm_we_o = 0, wbm_adr_o = STATUS address.
REQ-011 On ack in RD:
- If wbm_dat_i[0] = 1, clear the busy bit and increment done_cnt_o, saturating at 16'hFFFF.
- Set poll_ptr = target.
- Go to GAP.
REQ-012 GAP SHALL load the poll timer with POLL_GAP. It returns to IDLE the next cycle. The timer decrements by 1 per cycle down to 0 in every state.
REQ-013 wbm_cyc_o and wbm_stb_o SHALL drop in the cycle after the ack edge. Back-to-back transactions therefore have at least one idle cycle between them.
REQ-014 The ack counter SHALL count cycles in WR/RD. When it reaches ACK_TMO with no ack:
- drop cyc/stb and set err_o, which stays set until reset;
- return to IDLE;
- a WR timeout pops and discards the job, and the instance stays free;
- an RD timeout leaves busy unchanged.
REQ-015 Latency: a job accepted at edge N into an empty FIFO, with a free instance and the FSM in IDLE, SHALL have wbm_cyc_o = 1 after edge N+1.
REQ-016 A push and a pop on the same edge SHALL leave the FIFO count unchanged.
REQ-017 If no instance is free, a non-empty FIFO SHALL hold its jobs and polling SHALL continue.
REQ-018 All Wishbone outputs SHALL be registered. The data, address and select outputs SHALL be 0 when cyc is 0.

Reset
REQ-019 On an edge with wb_rst_i = 0, the block SHALL set:
- FSM = IDLE, FIFO empty;
- rr_ptr = poll_ptr = 0, poll timer = 0, ack counter = 0;
- wbm_cyc_o, wbm_stb_o and wbm_we_o = 0; wbm_sel_o, wbm_adr_o and wbm_dat_o = 0;
- busy_o = 0, done_cnt_o = 0, err_o = 0;
- job_ready_o = 1 from the first cycle after reset.
REQ-020 Reset asserted mid-transaction SHALL drop cyc/stb on that edge and discard the in-flight job.

Structure
REQ-021 A shared package ren_conv_pkg SHALL hold:
- the FSM state encoding;
- the CTRL/STATUS offsets;
- the base 8'h30;
- the done and start bit positions.
REQ-022 The FIFO SHALL be the sub-module ren_job_fifo, parameterised by width and depth, with full/empty/count outputs.

Verification
REQ-023 Single job: after reset, push cfg 32'h0000_1230 -> WR to 32'h3000_0000 with data 32'h0000_1231. After ack, busy_o = 4'b0001.
REQ-024 Fill and poll: push 5 jobs with no STATUS done -> 4 WRs go to instances 0,1,2,3 in order. The fifth job stays queued and RD polls cycle through 0x3x00_0004.
REQ-025 Completion: instance 2 returns STATUS 1 -> busy_o[2] clears and done_cnt_o increments by 1. The queued job is then written to 32'h3200_0000.
REQ-026 Back-pressure: hold job_valid_i high for 8 pushes with no acks -> job_ready_o = 0 after the 8th accept, or the 9th if one pop occurred.
REQ-027 Timeout: withhold wbm_ack_i for 16 cycles in WR -> cyc drops, err_o = 1, and the job is discarded with busy_o unchanged.
REQ-028 Reset mid-RD: drive wb_rst_i = 0 during RD -> all outputs reach their REQ-019 values on that edge.

Source files
------------

// File: rtl/ren_conv_pkg.sv
// ren_conv_pkg: shared FSM encoding, register map and bit positions for the convolver scheduler
package ren_conv_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD, GAP} state_t;
  localparam logic [31:0] CTRL_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
  localparam logic [7:0] BASE_HI = 8'h30;
  localparam int DONE_BIT = 0;
  localparam int START_BIT = 0;
  function automatic logic [31:0] inst_adr(input logic [7:0] idx, input logic [31:0] ofs);
    return {BASE_HI + idx, 24'h0} | ofs;
  endfunction
endpackage

// File: rtl/ren_conv_sched_if.sv
// ren_conv_sched_if: Wishbone master bus between the scheduler and the convolver fabric
interface ren_conv_sched_if;
  logic wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0] wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  modport master (output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, input wbm_dat_i, wbm_ack_i);
  modport slave (input wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, output wbm_dat_i, wbm_ack_i);
endinterface

// File: rtl/ren_job_fifo.sv
// ren_job_fifo: synchronous job FIFO with full/empty/count and first-word-fall-through head
module ren_job_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  input logic push,
  input logic pop,
  input logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
    if (!wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ren_conv_sched.sv
// ren_conv_sched: queues convolver jobs, dispatches them over Wishbone and polls instances for completion
module ren_conv_sched
  import ren_conv_pkg::*;
#(
  parameter int NO_OF_INSTS = 4,
  parameter int JOB_DEPTH = 8,
  parameter int POLL_GAP = 4,
  parameter int ACK_TMO = 16
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  input logic job_valid_i,
  output logic job_ready_o,
  input logic [31:0] job_cfg_i,
  ren_conv_sched_if.master wbm,
  output logic [NO_OF_INSTS-1:0] busy_o,
  output logic [15:0] done_cnt_o,
  output logic err_o
);
  localparam int IW = NO_OF_INSTS > 1 ? $clog2(NO_OF_INSTS) : 1;
  localparam int PW = $clog2(POLL_GAP + 1);
  localparam int AW = $clog2(ACK_TMO + 1);
  localparam int FCW = $clog2(JOB_DEPTH) + 1;
  state_t state, next;
  logic [IW-1:0] rr_ptr, poll_ptr, tgt, tgt_d, free_idx, poll_idx, fi, pi;
  logic free_hit, poll_hit, in_xfer, tmo, pop, empty, full;
  logic [PW-1:0] poll_tmr;
  logic [AW-1:0] ack_cnt;
  logic [31:0] head, adr_d, dat_d;
  logic [FCW-1:0] fifo_cnt;
  logic cyc_d, we_d, unused_ok;
  logic [3:0] sel_d;
  assign job_ready_o = !full;
  assign in_xfer = state == WR || state == RD;
  assign tmo = in_xfer && !wbm.wbm_ack_i && ack_cnt == AW'(ACK_TMO - 1);
  assign pop = state == WR && (wbm.wbm_ack_i || tmo);
  assign unused_ok = ^{fifo_cnt, wbm.wbm_dat_i};
  ren_job_fifo #(.WIDTH(32), .DEPTH(JOB_DEPTH)) u_fifo (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .push(job_valid_i),
    .pop(pop),
    .din(job_cfg_i),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_cnt)
  );
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    poll_hit = 1'b0;
    poll_idx = '0;
    fi = '0;
    pi = '0;
    for (int k = 0; k < NO_OF_INSTS; k++) begin
      fi = IW'((int'(rr_ptr) + k) % NO_OF_INSTS);
      pi = IW'((int'(poll_ptr) + k + 1) % NO_OF_INSTS);
      if (!free_hit && !busy_o[fi]) begin
        free_hit = 1'b1;
        free_idx = fi;
      end
      if (!poll_hit && busy_o[pi]) begin
        poll_hit = 1'b1;
        poll_idx = pi;
      end
    end
  end
  always_comb begin
    next = state;
    if (state == IDLE) next = (!empty && free_hit) ? WR : (poll_hit && poll_tmr == '0) ? RD : IDLE;
    else if (state == GAP) next = IDLE;
    else next = wbm.wbm_ack_i ? (state == RD ? GAP : IDLE) : tmo ? IDLE : state;
  end
  always_comb begin
    tgt_d = state == IDLE ? (next == WR ? free_idx : poll_idx) : tgt;
    cyc_d = next == WR || next == RD;
    we_d = next == WR;
    sel_d = cyc_d ? 4'hF : 4'h0;
    adr_d = cyc_d ? inst_adr(8'(tgt_d), we_d ? CTRL_OFS : STATUS_OFS) : '0;
    dat_d = we_d ? head | (32'h1 << START_BIT) : '0;
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state <= IDLE;
      tgt <= '0;
      rr_ptr <= '0;
      poll_ptr <= '0;
      poll_tmr <= '0;
      ack_cnt <= '0;
      busy_o <= '0;
      done_cnt_o <= '0;
      err_o <= 1'b0;
      wbm.wbm_cyc_o <= 1'b0;
      wbm.wbm_stb_o <= 1'b0;
      wbm.wbm_we_o <= 1'b0;
      wbm.wbm_sel_o <= '0;
      wbm.wbm_adr_o <= '0;
      wbm.wbm_dat_o <= '0;
    end else begin
      state <= next;
      tgt <= tgt_d;
      poll_tmr <= state == GAP ? PW'(POLL_GAP) : poll_tmr - PW'(poll_tmr != '0);
      ack_cnt <= (in_xfer && next == state) ? ack_cnt + AW'(1) : '0;
      if (state == WR && wbm.wbm_ack_i) begin
        busy_o[tgt] <= 1'b1;
        rr_ptr <= tgt == IW'(NO_OF_INSTS - 1) ? '0 : tgt + IW'(1);
      end
      if (state == RD && wbm.wbm_ack_i) begin
        poll_ptr <= tgt;
        if (wbm.wbm_dat_i[DONE_BIT]) begin
          busy_o[tgt] <= 1'b0;
          done_cnt_o <= done_cnt_o + 16'(done_cnt_o != 16'hFFFF);
        end
      end
      if (tmo) err_o <= 1'b1;
      wbm.wbm_cyc_o <= cyc_d;
      wbm.wbm_stb_o <= cyc_d;
      wbm.wbm_we_o <= we_d;
      wbm.wbm_sel_o <= sel_d;
      wbm.wbm_adr_o <= adr_d;
      wbm.wbm_dat_o <= dat_d;
    end
  end
endmodule

// File: tb/tb_ren_conv_sched.sv
// tb_ren_conv_sched: directed scoreboard bench with a Wishbone slave model for ren_conv_sched
module tb_ren_conv_sched;
  typedef struct {logic [31:0] adr; logic [31:0] dat;} txn_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic job_valid = 1'b0;
  logic [31:0] job_cfg = '0;
  logic job_ready, err;
  logic [3:0] busy;
  logic [15:0] done_cnt;
  logic [3:0] done_mask = '0;
  logic [3:0] ri;
  bit hold_ack = 1'b0;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int acc, n;
  txn_t exp_q[$];
  txn_t t_sb;
  int rd_q[$];
  int seq[5] = '{1, 2, 3, 0, 1};

  ren_conv_sched_if bus();

  ren_conv_sched dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst_n),
    .job_valid_i(job_valid),
    .job_ready_o(job_ready),
    .job_cfg_i(job_cfg),
    .wbm(bus),
    .busy_o(busy),
    .done_cnt_o(done_cnt),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    job_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    rd_q.delete();
    done_mask = '0;
    wr_cnt = 0;
  endtask

  task automatic push(input logic [31:0] cfg, input int inst, input bit sb);
    check("job_ready", 32'(job_ready), 1);
    job_cfg = cfg;
    job_valid = 1'b1;
    if (sb) exp_q.push_back('{adr: {8'h30 + 8'(inst), 24'h0}, dat: cfg | 32'h1});
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_wr(input int target);
    for (int i = 0; i < 300 && wr_cnt < target; i++) @(negedge clk);
    check("wr_wait", 32'(wr_cnt), 32'(target));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cyc"}, 32'(bus.wbm_cyc_o), 0);
    check({tag, "_stb"}, 32'(bus.wbm_stb_o), 0);
    check({tag, "_we"}, 32'(bus.wbm_we_o), 0);
    check({tag, "_sel"}, 32'(bus.wbm_sel_o), 0);
    check({tag, "_adr"}, bus.wbm_adr_o, 0);
    check({tag, "_dat"}, bus.wbm_dat_o, 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done_cnt), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_ready"}, 32'(job_ready), 1);
  endtask

  always @(negedge clk) begin
    if (bus.wbm_ack_i) begin
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = '0;
      check("cyc_drop", 32'(bus.wbm_cyc_o), 0);
    end else if (rst_n && bus.wbm_cyc_o && !hold_ack) begin
      if (bus.wbm_we_o) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          t_sb = exp_q.pop_front();
          check("wr_adr", bus.wbm_adr_o, t_sb.adr);
          check("wr_dat", bus.wbm_dat_o, t_sb.dat);
        end
        check("wr_sel", 32'(bus.wbm_sel_o), 32'hF);
        wr_cnt++;
      end else begin
        ri = bus.wbm_adr_o[27:24];
        check("rd_adr", bus.wbm_adr_o & 32'hF0FF_FFFF, 32'h3000_0004);
        check("rd_inst", 32'(ri < 4'd4), 1);
        bus.wbm_dat_i = {31'b0, done_mask[ri[1:0]]};
        done_mask[ri[1:0]] = 1'b0;
        rd_q.push_back(int'(ri));
      end
      bus.wbm_ack_i = 1'b1;
    end
  end

  initial begin
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    do_reset();
    check_idle_outputs("reset");

    push(32'h0000_1230, 0, 1'b1);
    @(negedge clk);
    check("latency_cyc", 32'(bus.wbm_cyc_o), 1);
    wait_wr(1);
    @(negedge clk);
    check("single_busy", 32'(busy), 32'h1);

    do_reset();
    for (int k = 0; k < 4; k++) push(32'hC0DE_0000 + 32'(k << 4), k, 1'b1);
    push(32'hC0DE_0040, 2, 1'b1);
    wait_wr(4);
    @(negedge clk);
    check("fill_busy", 32'(busy), 32'hF);
    check("fill_queued", 32'(exp_q.size()), 1);
    for (int i = 0; i < 300 && rd_q.size() < 5; i++) @(negedge clk);
    check("poll_wait", 32'(rd_q.size() >= 5), 1);
    if (rd_q.size() >= 5) for (int i = 0; i < 5; i++) check("poll_seq", 32'(rd_q[i]), 32'(seq[i]));
    check("poll_no_wr", 32'(wr_cnt), 4);
    done_mask = 4'b0100;
    wait_wr(5);
    @(negedge clk);
    check("done_cnt", 32'(done_cnt), 1);
    check("refill_busy", 32'(busy), 32'hF);
    check("sb_drained", 32'(exp_q.size()), 0);

    hold_ack = 1'b1;
    do_reset();
    job_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && job_ready; i++) begin
      job_cfg = 32'hB000_0000 + 32'(i << 4);
      acc++;
      @(negedge clk);
    end
    job_valid = 1'b0;
    check("bp_accepts", 32'(acc), 8);
    check("bp_ready_low", 32'(job_ready), 0);
    repeat (30) @(negedge clk);
    check("bp_ready_back", 32'(job_ready), 1);
    check("bp_err", 32'(err), 1);

    do_reset();
    check("tmo_err_clr", 32'(err), 0);
    push(32'h0000_0AB0, 0, 1'b0);
    for (int i = 0; i < 10 && !bus.wbm_cyc_o; i++) @(negedge clk);
    check("tmo_cyc", 32'(bus.wbm_cyc_o), 1);
    n = 0;
    while (bus.wbm_cyc_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("tmo_cycles", 32'(n), 16);
    check("tmo_err", 32'(err), 1);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_ready", 32'(job_ready), 1);
    repeat (4) @(negedge clk);
    check("tmo_discard", 32'(bus.wbm_cyc_o), 0);
    check("tmo_sticky", 32'(err), 1);

    hold_ack = 1'b0;
    do_reset();
    push(32'h0000_5670, 0, 1'b1);
    wait_wr(1);
    hold_ack = 1'b1;
    for (int i = 0; i < 20 && !(bus.wbm_cyc_o && !bus.wbm_we_o); i++) @(negedge clk);
    check("rd_pending", 32'(bus.wbm_cyc_o && !bus.wbm_we_o), 1);
    check("rd_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_rd");
    rst_n = 1'b1;
    hold_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
